// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state encoding and instruction field positions for the hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_MEM_WAIT = 2'd2} state_e;
  localparam int RS1_LSB   = 15;
  localparam int RS2_LSB   = 20;
  localparam int REG_IDX_W = 5;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating counters of IF/ID stall and flush cycles
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);
  logic [CNT_W-1:0] r_stall, r_flush;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_stall <= r_stall + CNT_W'(i_stall && !(&r_stall));
      r_flush <= r_flush + CNT_W'(i_flush && !(&r_flush));
    end
  end
  assign stall_cycles = r_stall;
  assign flush_cycles = r_flush;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: IF/ID + PC sequencing for load-use, branch redirect and imem wait.
// HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 15,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          IFID_Instruction,
  input  logic                 IDEX_MemRead,
  input  logic [REG_IDX_W-1:0] IDEX_rd,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  output logic                 pc_write,
  output logic                 ifid_stall,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 wait_timeout,
  output logic [1:0]           state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_cycles
`endif
);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  state_e r_state, w_next;
  logic [2:0] r_flush_cnt;
  logic [7:0] r_wait_cnt, w_wait_inc;
  logic r_timeout;
  logic [REG_IDX_W-1:0] w_rs1, w_rs2;
  logic w_flush, w_wait, w_load_use;
  assign w_rs1 = IFID_Instruction[RS1_LSB +: REG_IDX_W];
  assign w_rs2 = IFID_Instruction[RS2_LSB +: REG_IDX_W];
  // an in-progress flush owns the cycle; imem readiness is irrelevant while IF/ID is being cleared
  assign w_flush = branch_taken || r_state == ST_FLUSH;
  assign w_wait = !w_flush && !imem_ready;
  assign w_load_use = !w_flush && !w_wait && IDEX_MemRead && IDEX_rd != '0 &&
                      (IDEX_rd == w_rs1 || IDEX_rd == w_rs2);
  assign w_wait_inc = r_wait_cnt + 8'(r_wait_cnt != 8'hFF);
  always_comb begin
    w_next = branch_taken ? (FLUSH_CYCLES > 1 ? ST_FLUSH : ST_RUN) :
             r_state == ST_FLUSH ? (r_flush_cnt <= 3'd1 ? ST_RUN : ST_FLUSH) :
             w_wait ? ST_MEM_WAIT : ST_RUN;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_flush_cnt <= branch_taken ? FLUSH_LOAD : r_flush_cnt - 3'(r_state == ST_FLUSH);
      r_wait_cnt  <= w_wait ? w_wait_inc : '0;
      if (w_wait && w_wait_inc == 8'(MAX_WAIT)) r_timeout <= 1'b1;
    end
  end
  assign pc_write     = !reset && !w_wait && !w_load_use;
  assign ifid_stall   = !reset && (w_wait || w_load_use);
  assign ifid_flush   = !reset && w_flush;
  assign idex_bubble  = !reset && (w_flush || w_wait || w_load_use);
  assign wait_timeout = r_timeout;
  assign state_o      = r_state;
`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk          (clk),
    .reset        (reset),
    .i_stall      (ifid_stall),
    .i_flush      (ifid_flush),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of the hazard controller (FLUSH_CYCLES=2, MAX_WAIT=15).
// HAZARD_PERF_CNT_EN also checks the perf counters clear on reset.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] instr = '0;
  logic mem_read = 1'b0;
  logic [4:0] rd = '0;
  logic branch = 1'b0;
  logic ready = 1'b1;
  logic pc_write, ifid_stall, ifid_flush, idex_bubble, wait_timeout;
  logic [1:0] state_o;
  int n_cmp = 0;
  int n_err = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .MAX_WAIT(15), .CNT_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .IFID_Instruction (instr),
    .IDEX_MemRead     (mem_read),
    .IDEX_rd          (rd),
    .branch_taken     (branch),
    .imem_ready       (ready),
    .pc_write         (pc_write),
    .ifid_stall       (ifid_stall),
    .ifid_flush       (ifid_flush),
    .idex_bubble      (idex_bubble),
    .wait_timeout     (wait_timeout),
    .state_o          (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles     (stall_cycles),
    .flush_cycles     (flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, 5'd1, 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // outputs packed as {pc_write, ifid_stall, ifid_flush, idex_bubble}
  task automatic chk_all(input string tag, input logic [3:0] outs, input logic [1:0] st, input logic to);
    chk({tag, ".outs"}, {28'd0, pc_write, ifid_stall, ifid_flush, idex_bubble}, {28'd0, outs});
    chk({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
    chk({tag, ".timeout"}, {31'd0, wait_timeout}, {31'd0, to});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk_all("reset", 4'b0000, 2'd0, 1'b0);
    step(); reset = 1'b0; #1;
    chk_all("normal", 4'b1000, 2'd0, 1'b0);
    step(); mem_read = 1'b1; rd = 5'd5; instr = mk(5'd5, 5'd3); #1;
    chk_all("lu_rs1", 4'b0101, 2'd0, 1'b0);
    step(); mem_read = 1'b0; #1;
    chk_all("lu_after", 4'b1000, 2'd0, 1'b0);
    step(); mem_read = 1'b1; rd = 5'd7; instr = mk(5'd1, 5'd7); #1;
    chk_all("lu_rs2", 4'b0101, 2'd0, 1'b0);
    step(); rd = 5'd6; #1;
    chk_all("lu_nomatch", 4'b1000, 2'd0, 1'b0);
    step(); rd = 5'd0; instr = mk(5'd0, 5'd0); #1;
    chk_all("x0_filter", 4'b1000, 2'd0, 1'b0);
    step(); branch = 1'b1; rd = 5'd5; instr = mk(5'd5, 5'd2); #1;
    chk_all("br_cycle", 4'b1011, 2'd0, 1'b0);
    step(); branch = 1'b0; #1;
    chk_all("br_flush", 4'b1011, 2'd1, 1'b0);
    step(); #1;
    chk_all("br_done_lu", 4'b0101, 2'd0, 1'b0);
    step(); mem_read = 1'b0; ready = 1'b0; #1;
    for (int k = 1; k <= 16; k++) begin
      chk_all($sformatf("wait%0d", k), 4'b0101, k == 1 ? 2'd0 : 2'd2, k >= 16);
      step(); #1;
    end
    ready = 1'b1; #1;
    chk_all("wait_exit", 4'b1000, 2'd2, 1'b1);
    step(); #1;
    chk_all("wait_run", 4'b1000, 2'd0, 1'b1);
    step(); ready = 1'b0; #1;
    chk_all("mw_enter", 4'b0101, 2'd0, 1'b1);
    step(); branch = 1'b1; #1;
    chk_all("mw_branch", 4'b1011, 2'd2, 1'b1);
    step(); branch = 1'b0; ready = 1'b1; #1;
    chk_all("mw_flush", 4'b1011, 2'd1, 1'b1);
    step(); #1;
    chk_all("mw_run", 4'b1000, 2'd0, 1'b1);
    step(); branch = 1'b1; #1;
    step(); branch = 1'b0; #1;
    chk_all("rst_pre", 4'b1011, 2'd1, 1'b1);
    reset = 1'b1; #1;
    chk_all("rst_flush", 4'b0000, 2'd0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall", stall_cycles, 32'd0);
    chk("perf_flush", flush_cycles, 32'd0);
`else
    chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
`endif
    step(); reset = 1'b0; #1;
    chk_all("post_rst", 4'b1000, 2'd0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
